// File: rtl/func_sweep_checker.sv
// Exhaustive 4-input truth-table sweeper: drives all 16 vectors, samples the
// function under test, and compares it against a golden table.
module func_sweep_checker #(
    parameter logic [15:0] EXPECTED      = 16'hA4A6,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic        P,
    output logic        Q,
    output logic        R,
    output logic        S,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] index;
    logic [3:0] settle_cnt;
    logic       miss;
    logic       last_vec;
    logic       settle_end;

    assign miss       = (f_in != EXPECTED[index]);
    assign last_vec   = (index == 4'd15);
    assign settle_end = (settle_cnt == SETTLE_LAST);

    // index is zero outside a sweep, so the vector is a plain register view
    assign {P, Q, R, S} = index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_end) state_next = SAMPLE;
            SAMPLE:  state_next = last_vec ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index          <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
            fail_valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        index          <= '0;
                        settle_cnt     <= '0;
                        captured       <= '0;
                        mismatch_count <= '0;
                        first_fail     <= '0;
                        fail_valid     <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_end) settle_cnt <= '0;
                    else            settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    captured[index] <= f_in;
                    if (miss) begin
                        if (mismatch_count != 5'd16)
                            mismatch_count <= mismatch_count + 5'd1;
                        if (!fail_valid) begin
                            first_fail <= index;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        index <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // include this final sample in the verdict
                        pass  <= (mismatch_count == 5'd0) && !miss;
                    end else begin
                        index <= index + 4'd1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_func_sweep_checker.sv
// Scoreboard bench for func_sweep_checker: golden, stuck-at and random
// functions, vector sequencing, mid-sweep reset and held-start sweeps.
module tb_func_sweep_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [15:0] tbl;

    logic p0, q0, r0, s0, busy0, done0, pass0, fv0;
    logic [15:0] cap0;
    logic [4:0]  mc0;
    logic [3:0]  ff0;
    logic f0;

    logic p1, q1, r1, s1, busy1, done1, pass1, fv1;
    logic [15:0] cap1;
    logic [4:0]  mc1;
    logic [3:0]  ff1;
    logic f1;

    logic [3:0] vec0, vec1;
    assign vec0 = {p0, q0, r0, s0};
    assign vec1 = {p1, q1, r1, s1};
    assign f0 = tbl[vec0];
    assign f1 = tbl[vec1];

    always #5 clk = ~clk;

    func_sweep_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f0),
        .P(p0), .Q(q0), .R(r0), .S(s0),
        .busy(busy0), .done(done0), .pass(pass0),
        .captured(cap0), .mismatch_count(mc0),
        .first_fail(ff0), .fail_valid(fv0)
    );

    func_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .f_in(f1),
        .P(p1), .Q(q1), .R(r1), .S(s1),
        .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .mismatch_count(mc1),
        .first_fail(ff1), .fail_valid(fv1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // F = QRS + ~QR~S + ~P~RS + Q~RS
    function automatic logic [15:0] golden_tt();
        logic [15:0] t;
        logic p, q, r, s;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            {p, q, r, s} = 4'(i);
            t[i] = (q & r & s) | (~q & r & ~s) | (~p & ~r & s) | (q & ~r & s);
        end
        return t;
    endfunction

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  mc;
        logic [3:0]  ff;
        logic        fv;
        logic        pass;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t make_exp(input logic [15:0] t);
        exp_t e;
        logic [15:0] d;
        d      = t ^ golden_tt();
        e.cap  = t;
        e.mc   = 5'($countones(d));
        e.ff   = '0;
        for (int i = 15; i >= 0; i--)
            if (d[i]) e.ff = 4'(i);
        e.fv   = (d != 0);
        e.pass = (d == 0);
        return e;
    endfunction

    int cyc = 0;
    int acc0 = 0, acc1 = 0;
    int last_done = 0;
    int vec_err0 = 0, vec_err1 = 0;
    int sweeps = 0;
    bit inflight0 = 0, inflight1 = 0;
    bit hold_mode = 0;
    logic busy_q0 = 0, busy_q1 = 0;

    always @(negedge clk) begin
        exp_t e;
        int rel;
        cyc++;
        if (rst) begin
            sb.delete();
            inflight0 = 0;
            busy_q0   = 0;
        end else begin
            if (busy0 && !busy_q0) begin
                if (hold_mode && last_done > 0)
                    check("idle_gap", 32'(cyc - last_done), 2);
                acc0      = cyc;
                inflight0 = 1;
                vec_err0  = 0;
                sb.push_back(make_exp(tbl));
            end
            if (inflight0 && busy0) begin
                rel = cyc - acc0 + 1;
                if (vec0 != 4'((rel - 1) / 3)) vec_err0++;
            end
            if (done0) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(cyc - acc0 + 1), 49);
                    check("captured", cap0, e.cap);
                    check("mismatch_count", mc0, e.mc);
                    check("fail_valid", fv0, e.fv);
                    if (e.fv) check("first_fail", ff0, e.ff);
                    check("pass", pass0, e.pass);
                    check("vec_seq", 32'(vec_err0), 0);
                    check("vec_at_done", vec0, 0);
                    check("busy_at_done", busy0, 0);
                end
                last_done = cyc;
                inflight0 = 0;
                sweeps++;
            end
            busy_q0 = busy0;
        end
    end

    always @(negedge clk) begin
        int rel;
        if (rst) begin
            inflight1 = 0;
            busy_q1   = 0;
        end else begin
            if (busy1 && !busy_q1) begin
                acc1      = cyc;
                inflight1 = 1;
                vec_err1  = 0;
            end
            if (inflight1 && busy1) begin
                rel = cyc - acc1 + 1;
                if (vec1 != 4'((rel - 1) / 2)) vec_err1++;
            end
            if (done1 && inflight1) begin
                check("s1_latency", 32'(cyc - acc1 + 1), 33);
                check("s1_vec_seq", 32'(vec_err1), 0);
                check("s1_vec_at_done", vec1, 0);
                inflight1 = 0;
            end
            busy_q1 = busy1;
        end
    end

    task automatic wait_sweeps(input int target, input int budget);
        int n;
        n = 0;
        while (sweeps < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sweeps < target) check("sweep_timeout", 32'(sweeps), 32'(target));
    endtask

    task automatic run_sweep(input logic [15:0] t);
        int target;
        target = sweeps + 1;
        @(negedge clk);
        #1;
        tbl   = t;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_sweeps(target, 200);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] g;
        int n;
        int target;
        g     = golden_tt();
        rst   = 1'b1;
        start = 1'b0;
        tbl   = g;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state_a", {cap0, mc0, ff0, fv0, pass0}, 0);
        check("rst_state_b", {vec0, busy0, done0}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(g);
        check("golden_captured", cap0, 16'hA4A6);
        check("hold_after_done", {mc0, fv0, pass0}, {5'd0, 1'b0, 1'b1});
        run_sweep(16'h0000);
        run_sweep(16'hFFFF);
        run_sweep(g ^ 16'h8000);
        run_sweep(16'($urandom));
        run_sweep(16'($urandom));

        // abort a stuck-at-1 sweep at vector 5
        @(negedge clk);
        #1;
        tbl   = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (vec0 != 4'd5 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_index5", vec0, 5);
        check("mid_captured_nz", 32'(cap0 != 0), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_a", {cap0, mc0, ff0, fv0, pass0}, 0);
        check("async_rst_b", {vec0, busy0, done0}, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        target = sweeps;
        repeat (60) @(negedge clk);
        #1;
        check("no_done_after_abort", 32'(sweeps), 32'(target));
        run_sweep(g);
        check("post_rst_captured", cap0, 16'hA4A6);

        // start held high: back-to-back sweeps
        @(negedge clk);
        #1;
        hold_mode = 1;
        last_done = 0;
        tbl       = 16'h0000;
        start     = 1'b1;
        wait_sweeps(sweeps + 3, 400);
        start = 1'b0;
        n = 0;
        while ((busy0 || busy1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_after_hold", {busy0, busy1}, 0);
        hold_mode = 0;
        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
